multdiv_sequencer: RTL
======================

Name: multdiv_sequencer

Overview:
Multi-cycle controller for mul/div in the 5-stage pipeline. It sits beside the execute stage and takes the decoder's mul/div type bits for the instruction in X. It latches the operands, pulses a single start strobe to the iterative multdiv unit, and stalls F/D/X until the result arrives. It then issues exactly one writeback: the product/quotient to rd, or an exception code to r30 (rstatus).

Parameters:
MAX_CYCLES, 40, BUSY cycles allowed before a timeout is declared (range 2..63)
MUL_EXC_CODE, 4, value written to r30 on mul overflow or mul timeout
DIV_EXC_CODE, 5, value written to r30 on divide-by-zero or div timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
x_mul  in  1  X-stage instruction is mul (decoder type bit 7)
x_div  in  1  X-stage instruction is div (decoder type bit 8)
x_rd  in  5  destination register of X instruction
x_operandA  in  32  rs value after bypass
x_operandB  in  32  rt value after bypass
cancel  in  1  synchronous abort of in-flight op (pipeline flush)
ctrl_MULT  out  1  one-cycle start strobe to multdiv
ctrl_DIV  out  1  one-cycle start strobe to multdiv
md_operandA  out  32  latched operand A, stable from START to DONE
md_operandB  out  32  latched operand B, stable from START to DONE
md_result  in  32  multdiv result
md_ready  in  1  result valid this cycle
md_exception  in  1  overflow/div0; qualified by md_ready
stall  out  1  hold PC, F/D and D/X latches
busy  out  1  state != IDLE
wb_valid  out  1  one-cycle regfile write request
wb_rd  out  5  write register
wb_data  out  32  write data
timeout  out  1  sticky: an op exceeded MAX_CYCLES

Behaviour:
- Reset (async): state=IDLE; all outputs and internal registers 0; no strobe is issued after release.
- States: IDLE, START, BUSY, DONE. Encoding is free.
- Request: req = (x_mul|x_div) & ~cancel.
  - x_mul and x_div together are illegal; mul wins.
- IDLE:
  - stall = req, combinationally.
  - On req: latch operands, rd, and op; next state START.
- START:
  - ctrl_MULT or ctrl_DIV = 1 for this cycle only.
  - Cycle counter cleared to 0; stall=1; next state BUSY.
- BUSY:
  - stall=1; counter increments each cycle.
  - md_ready=1: capture md_result/md_exception; next state DONE. md_ready takes precedence over timeout in the same cycle.
  - counter==MAX_CYCLES-1 with no md_ready: set timeout; treat as exception; next state DONE.
  - md_ready during START is ignored.
- DONE:
  - stall=0, so the X instruction advances this cycle; wb_valid=1 for exactly this cycle.
  - x_mul/x_div are ignored this cycle (no re-issue); next state IDLE.
- Writeback selection:
  - Exception or timeout: wb_rd=30; wb_data=MUL_EXC_CODE or DIV_EXC_CODE, zero-extended.
  - Otherwise: wb_rd=latched rd; wb_data=result.
  - rd==0 with no exception: wb_valid=0.
- wb_rd and wb_data are 0 whenever wb_valid=0.
- Latency: req seen at cycle T → strobe at T+1. md_ready in the k-th BUSY cycle (k≥1, BUSY starting T+2) → DONE/writeback at T+k+2. Total stall cycles = k+2.
- cancel:
  - In START/BUSY: next state IDLE, no writeback, stall drops the following cycle.
  - In DONE: no effect; the writeback completes.
  - A late md_ready after cancel is ignored in IDLE.
- Back-to-back mul/div: the second is accepted in the IDLE cycle after DONE.
- Reset mid-operation: immediate IDLE; no writeback.
- timeout clears only on reset.

Test Plan:
- mul A=6, B=7, rd=5, md_ready in 3rd BUSY cycle → one ctrl_MULT pulse at T+1; stall high T..T+4; wb_valid at T+5 with rd=5, data=42.
- div A=10, B=0, md_exception=1 → wb_rd=30, wb_data=5, one ctrl_DIV pulse.
- mul, rd=0, result=9, no exception → wb_valid never asserts; block returns to IDLE.
- md_ready never asserted, MAX_CYCLES=40 → DONE after 40 BUSY cycles; wb r30=4; timeout=1 until reset.
- cancel in 2nd BUSY cycle → IDLE next cycle, no wb; md_ready pulse 1 cycle later ignored; a new div is accepted normally.
- Async reset in BUSY, then x_mul held through deassert → outputs 0 during reset; fresh START after release with a single strobe.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the iterative mul/div unit: latches operands, issues
// one start strobe, stalls the front of the pipe, then emits a single writeback.
module multdiv_sequencer #(
  parameter int          MAX_CYCLES   = 40,
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_mul,
  input  logic        x_div,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_operandA,
  input  logic [31:0] x_operandB,
  input  logic        cancel,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout
);

  // Handshake: md_ready is a single-cycle valid with no back-pressure; md_result and
  // md_exception are only looked at in BUSY while md_ready is high.
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t      state, nextState;
  logic        opMul;
  logic [4:0]  rdReg;
  logic [31:0] opA, opB, resReg;
  logic        excReg;
  logic [5:0]  cycleCount;
  logic        timeoutReg;
  logic        req, hitLimit;

  assign req      = (x_mul | x_div) & ~cancel;
  assign hitLimit = (cycleCount == 6'(MAX_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (req) nextState = START;
      START: nextState = cancel ? IDLE : BUSY;
      BUSY: begin
        if (cancel)                     nextState = IDLE;
        else if (md_ready || hitLimit)  nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opMul      <= 1'b0;
      rdReg      <= 5'd0;
      opA        <= 32'd0;
      opB        <= 32'd0;
      resReg     <= 32'd0;
      excReg     <= 1'b0;
      cycleCount <= 6'd0;
      timeoutReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            opMul  <= x_mul;  // mul wins when both type bits are set
            rdReg  <= x_rd;
            opA    <= x_operandA;
            opB    <= x_operandB;
            resReg <= 32'd0;
            excReg <= 1'b0;
          end
        end
        START: cycleCount <= 6'd0;
        BUSY: begin
          if (!cancel) begin
            cycleCount <= cycleCount + 6'd1;
            if (md_ready) begin
              resReg <= md_result;
              excReg <= md_exception;
            end else if (hitLimit) begin
              excReg     <= 1'b1;
              timeoutReg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md_operandA = opA;
  assign md_operandB = opB;
  assign timeout     = timeoutReg;
  assign busy        = (state != IDLE);
  assign ctrl_MULT   = (state == START) &&  opMul;
  assign ctrl_DIV    = (state == START) && !opMul;

  // In IDLE the stall follows the request combinationally, held low while in reset.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:        stall = req & ~reset;
      START, BUSY: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    if (state == DONE) begin
      if (excReg) begin
        wb_valid = 1'b1;
        wb_rd    = 5'd30;
        wb_data  = opMul ? MUL_EXC_CODE : DIV_EXC_CODE;
      end else if (rdReg != 5'd0) begin
        wb_valid = 1'b1;
        wb_rd    = rdReg;
        wb_data  = resReg;
      end
    end
  end

endmodule
